factorial_ctrl: RTL

Sequencing controller and multiply unit for the factorial datapath. It sits directly upstream of the 2-entry, 16-bit dual-write/dual-read register file and drives all of that file's write and read ports. Register 0 holds the running product (ACC) and register 1 holds the down-counter (CNT). It computes N! with a 16-cycle shift-add multiplier, reports a truncated 16-bit result, and raises a sticky overflow flag.

---
 rtl/factorial_pkg.sv | 26 ++
 rtl/factorial_if.sv | 47 ++++
 rtl/mul_shift_add.sv | 75 +++++++
 rtl/factorial_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/factorial_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : factorial_pkg
//  Purpose  : Shared types and constants for the factorial controller slice.
//  Revision : 1.0  initial release
// ============================================================================
package factorial_pkg;

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_N_WIDTH = 4;

    // Port 1 owns the accumulator, port 2 owns the down-counter.
    localparam logic ACC_ADDR = 1'b0;
    localparam logic CNT_ADDR = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_CHECK = 3'd2,
        S_MUL   = 3'd3,
        S_WB    = 3'd4,
        S_FIN   = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/factorial_if.sv
`default_nettype none
// ============================================================================
//  Module   : factorial_if
//  Purpose  : Request/result handshake plus register-file port bundle.
//  Revision : 1.0  initial release
// ============================================================================
interface factorial_if
    import factorial_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int N_WIDTH = DEF_N_WIDTH
);
    logic               START;
    logic [N_WIDTH-1:0] N_IN;
    logic               BUSY;
    logic               DONE;
    logic               OVF;
    logic [WIDTH-1:0]   RESULT;
    logic               WE1;
    logic               WE2;
    logic               WA1;
    logic               WA2;
    logic [WIDTH-1:0]   DATA_IN1;
    logic [WIDTH-1:0]   DATA_IN2;
    logic               REA1;
    logic               REA2;
    logic               RAA1;
    logic               RAA2;
    logic [WIDTH-1:0]   RDA1;
    logic [WIDTH-1:0]   RDA2;

    // slave: the controller; master: requester plus register file
    modport slave (
        input  START, N_IN, RDA1, RDA2,
        output BUSY, DONE, OVF, RESULT,
        output WE1, WE2, WA1, WA2, DATA_IN1, DATA_IN2,
        output REA1, REA2, RAA1, RAA2
    );

    modport master (
        output START, N_IN, RDA1, RDA2,
        input  BUSY, DONE, OVF, RESULT,
        input  WE1, WE2, WA1, WA2, DATA_IN1, DATA_IN2,
        input  REA1, REA2, RAA1, RAA2
    );
endinterface
`default_nettype wire

// File: rtl/mul_shift_add.sv
`default_nettype none
// ============================================================================
//  Module   : mul_shift_add
//  Purpose  : Iterative shift-add multiplier, one multiplier bit per cycle.
//  Revision : 1.0  initial release
// ============================================================================
module mul_shift_add #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = WIDTH
) (
    input  wire logic               CLK,
    input  wire logic               RST,
    input  wire logic               LOAD,
    input  wire logic [WIDTH-1:0]   A,
    input  wire logic [WIDTH-1:0]   B,
    output logic                    BUSY,
    output logic [2*WIDTH-1:0]      PRODUCT
);
    localparam int            CW   = $clog2(MUL_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      iter_q, iter_d;
    logic               run_q, run_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        iter_d   = iter_q;
        run_d    = run_q;
        if (LOAD) begin
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = B;
            prod_d   = '0;
            iter_d   = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            iter_d   = iter_q + CW'(1);
            if (iter_q == LAST) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            iter_q   <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            iter_q   <= iter_d;
            run_q    <= run_d;
        end
    end

    // Drops during the final iteration so the consumer steps out on the
    // same edge that completes the product.
    assign BUSY    = run_q && (iter_q != LAST);
    assign PRODUCT = prod_q;

endmodule
`default_nettype wire

// File: rtl/factorial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : factorial_ctrl
//  Purpose  : Sequences N! over a 2-entry register file (ACC, CNT).
//  Revision : 1.0  initial release
// ============================================================================
module factorial_ctrl
    import factorial_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int N_WIDTH    = DEF_N_WIDTH,
    parameter int MUL_CYCLES = WIDTH
) (
    input  wire logic CLK,
    input  wire logic RST,
    factorial_if.slave bus
);
    state_t             state_q, state_d;
    logic [N_WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               we_q, we_d;
    logic               rea_q, rea_d;

    logic               mul_load;
    logic               mul_busy;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH-1:0]   data_in1;
    logic [WIDTH-1:0]   data_in2;

    mul_shift_add #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .CLK     (CLK),
        .RST     (RST),
        .LOAD    (mul_load),
        .A       (bus.RDA1),
        .B       (bus.RDA2),
        .BUSY    (mul_busy),
        .PRODUCT (mul_product)
    );

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        mul_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    n_d     = bus.N_IN;
                    ovf_d   = 1'b0;
                    state_d = S_INIT;
                end
            end
            S_INIT:  state_d = S_CHECK;
            S_CHECK: begin
                if (bus.RDA2 <= WIDTH'(1)) begin
                    result_d = bus.RDA1;
                    state_d  = S_FIN;
                end else begin
                    cnt_d    = bus.RDA2;
                    mul_load = 1'b1;
                    state_d  = S_MUL;
                end
            end
            S_MUL: begin
                if (!mul_busy) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                ovf_d   = ovf_q | (|mul_product[2*WIDTH-1:WIDTH]);
                state_d = S_CHECK;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Strobes are decoded from the next state so they line up with it.
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_FIN);
        we_d   = (state_d == S_INIT) || (state_d == S_WB);
        rea_d  = (state_d == S_CHECK);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            n_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            rea_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
            rea_q    <= rea_d;
        end
    end

    always_comb begin
        data_in1 = '0;
        data_in2 = '0;
        case (state_q)
            S_INIT: begin
                data_in1 = WIDTH'(1);
                data_in2 = {{(WIDTH-N_WIDTH){1'b0}}, n_q};
            end
            S_WB: begin
                data_in1 = mul_product[WIDTH-1:0];
                data_in2 = cnt_q - WIDTH'(1);
            end
            default: ;
        endcase
    end

    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.OVF      = ovf_q;
    assign bus.RESULT   = result_q;
    assign bus.WE1      = we_q;
    assign bus.WE2      = we_q;
    assign bus.WA1      = ACC_ADDR;
    assign bus.WA2      = we_q ? CNT_ADDR : ACC_ADDR;
    assign bus.DATA_IN1 = data_in1;
    assign bus.DATA_IN2 = data_in2;
    assign bus.REA1     = rea_q;
    assign bus.REA2     = rea_q;
    assign bus.RAA1     = ACC_ADDR;
    assign bus.RAA2     = rea_q ? CNT_ADDR : ACC_ADDR;

endmodule
`default_nettype wire
